seg595_scan: RTL and testbench
==============================

# seg595_scan

Parametrised scanning driver for a multiplexed N-digit 7-segment display fed through a chained pair of 74HC595 shift registers. Each scan slot captures one digit's segment pattern, applies blanking and polarity, and serialises the combined {segment, select} word MSB-first on DS/SHCP. It then pulses STCP and holds the digit for a fixed dwell time before moving to the next digit. It replaces the fixed 6-digit driver in `top`: digit count, segment width, shift-clock rate, dwell time and output polarities are all parameters, and it adds blanking, enable and frame status.

## Interface
- DIGITS, 6: number of digits scanned (1..16).
- SEG_W, 8: segment bits per digit (7 segments plus dp).
- SHCP_DIV, 2: clk cycles per SHCP half-period (≥1).
- SCAN_CNT, 50000: clk cycles per digit slot. Must be > 2·SHCP_DIV·N_BITS + SHCP_DIV.
- SEG_ACTIVE_LOW, 1: when 1, segment bits are inverted before shifting.
- SEL_ACTIVE_LOW, 0: when 1, select bits are inverted before shifting.
- Derived: N_BITS = SEG_W + DIGITS.

Ports:
- clk, input, 1: system clock. All logic is on its rising edge.
- rst, input, 1: asynchronous, active-low reset.
- en, input, 1: scan enable.
- seg_data, input, DIGITS·SEG_W: digit k occupies [k·SEG_W +: SEG_W]. Active-high: 1 = segment lit.
- blank, input, DIGITS: bit k = 1 forces digit k dark.
- shcp, output, 1: 595 shift clock.
- stcp, output, 1: 595 storage (latch) clock.
- DS, output, 1: 595 serial data.
- OE, output, 1: 595 output enable, active-low.
- frame_start, output, 1: one-cycle pulse when a digit-0 slot begins.
- busy, output, 1: high while the state machine is not in IDLE.

## Operation
- Reset values: shcp=0, stcp=0, DS=0, OE=1, frame_start=0, busy=0. State IDLE, digit index 0, all counters 0.
- States are IDLE → LOAD → SHIFT → LATCH → HOLD → LOAD …
- IDLE: wait for en=1, then go to LOAD.
- LOAD (1 cycle):
  - Capture seg_data for the current digit k.
  - Raw segments seg = blank[k] ? 0 : seg_data slice.
  - seg_out = seg, inverted if SEG_ACTIVE_LOW.
  - sel_out = one-hot bit k, inverted if SEL_ACTIVE_LOW.
  - Word = {seg_out, sel_out}.
  - Pulse frame_start if k=0.
  - The slot counter starts at 0 in this cycle.
- SHIFT: N_BITS bits, MSB first.
  - Per bit: DS updates on entry while shcp=0, held SHCP_DIV cycles; then shcp=1 for SHCP_DIV cycles.
  - DS is stable across each rising edge of shcp.
- LATCH: shcp=0, stcp=1 for SHCP_DIV cycles, then stcp=0.
  - At the end of the first LATCH after leaving IDLE, OE goes low.
- HOLD: wait until the slot counter reaches SCAN_CNT-1.
  - Then k = (k = DIGITS-1) ? 0 : k+1, and go to LOAD if en=1, otherwise to IDLE.
- en deasserted mid-slot:
  - OE goes to 1 on the next clk edge.
  - The current slot completes SHIFT and LATCH normally, then the block enters IDLE.
  - k is kept, so a re-enable resumes at the next digit.
- Changes to seg_data or blank outside the LOAD cycle do not affect the word currently being shifted.
- Reset asserted in any state forces the reset values immediately, with no partial latch pulse. After release the block starts at digit 0.

## Timing
- From en=1 sampled in IDLE: LOAD on the next cycle, and the first DS bit valid 1 cycle after LOAD.
- Bit i (0 = MSB) rising edge of shcp occurs at slot cycle 1 + 2·SHCP_DIV·i + SHCP_DIV.
- stcp high during slot cycles 1 + 2·SHCP_DIV·N_BITS through that value + SHCP_DIV − 1.
- Slot period is exactly SCAN_CNT cycles; a full frame is DIGITS·SCAN_CNT cycles. frame_start pulses are spaced DIGITS·SCAN_CNT apart while en=1.
- shcp and stcp are never high simultaneously.

## Test plan
- Defaults with SCAN_CNT=64; seg_data digit0 = 8'h3F, no blanking; release reset and set en=1.
  - Bits sampled on shcp rising edges = 14'b11000000_000001.
  - stcp pulse is 2 cycles wide; OE falls after that pulse.
- Run 6·64 cycles with distinct patterns per digit.
  - sel_out walks 000001 → 100000 → 000001.
  - frame_start pulse spacing = 384 cycles.
- blank = 6'b000100, digit2 seg = 8'hFF.
  - Digit 2 word has seg_out = 8'hFF (all off, active-low) and sel_out = 000100.
- Drop en mid-SHIFT of digit 3.
  - OE = 1 on the next cycle; the remaining bits and latch still complete; busy = 0 after HOLD.
  - Re-enable: the next slot is digit 4.
- Assert rst mid-LATCH.
  - stcp, shcp, DS = 0 and OE = 1 asynchronously.
  - After release and en=1, the first slot is digit 0.
- DIGITS=4, SEG_W=8, SHCP_DIV=1, SEL_ACTIVE_LOW=1, SCAN_CNT=32.
  - 12 bits per slot; digit1 sel_out = 4'b1101; wrap from 3 to 0.

Source files
------------

// File: rtl/seg595_scan.sv
// seg595_scan: scanning driver for an N-digit multiplexed 7-segment display
// behind two chained 74HC595 shift registers. Each digit slot loads one
// {segment, select} word, shifts it out MSB-first on DS/SHCP, pulses STCP,
// then holds the digit lit until the slot period expires.
module seg595_scan #(
  parameter int DIGITS         = 6,
  parameter int SEG_W          = 8,
  parameter int SHCP_DIV       = 2,
  parameter int SCAN_CNT       = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int SEL_ACTIVE_LOW = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [DIGITS*SEG_W-1:0] seg_data,
  input  logic [DIGITS-1:0]       blank,
  output logic                    shcp,
  output logic                    stcp,
  output logic                    DS,
  output logic                    OE,
  output logic                    frame_start,
  output logic                    busy,
  output logic [2:0]              state_dbg
);

  localparam int N_BITS = SEG_W + DIGITS;
  localparam int KW     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CW     = $clog2(SCAN_CNT);
  localparam int DW     = (SHCP_DIV > 1) ? $clog2(SHCP_DIV) : 1;
  localparam int BW     = $clog2(N_BITS);

  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_CNT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(SHCP_DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(N_BITS - 1);
  localparam logic [KW-1:0] K_LAST   = KW'(DIGITS - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SHIFT = 3'd2,
    LATCH = 3'd3,
    HOLD  = 3'd4
  } state_t;

  state_t              state;
  logic [KW-1:0]       k;
  logic [KW-1:0]       k_next;
  logic [CW-1:0]       slot_cnt;
  logic [DW-1:0]       div_cnt;
  logic [BW-1:0]       bit_cnt;
  logic [N_BITS-1:0]   shreg;

  logic [SEG_W-1:0]    seg_raw;
  logic [SEG_W-1:0]    seg_out;
  logic [DIGITS-1:0]   sel_raw;
  logic [DIGITS-1:0]   sel_out;
  logic [N_BITS-1:0]   word;

  assign state_dbg = state;

  // Build the word for the current digit: blanking, one-hot select, polarity.
  always_comb begin
    seg_raw = '0;
    sel_raw = '0;
    if (!blank[k]) seg_raw = seg_data[k*SEG_W +: SEG_W];
    sel_raw[k] = 1'b1;
    seg_out = (SEG_ACTIVE_LOW != 0) ? ~seg_raw : seg_raw;
    sel_out = (SEL_ACTIVE_LOW != 0) ? ~sel_raw : sel_raw;
    word    = {seg_out, sel_out};
    k_next  = (k == K_LAST) ? '0 : k + 1'b1;
  end

  // Scan state machine; all 595 outputs and status flags are registered here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= IDLE;
      k           <= '0;
      slot_cnt    <= '0;
      div_cnt     <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      shcp        <= 1'b0;
      stcp        <= 1'b0;
      DS          <= 1'b0;
      OE          <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      // Dropping enable darkens the display at once; the slot still drains.
      if (!en) OE <= 1'b1;
      if (state != IDLE) slot_cnt <= slot_cnt + 1'b1;
      case (state)
        IDLE: begin
          slot_cnt <= '0;
          if (en) begin
            state       <= LOAD;
            busy        <= 1'b1;
            frame_start <= (k == '0);
          end
        end
        LOAD: begin
          // Word is captured here so later input changes cannot disturb it.
          DS      <= word[N_BITS-1];
          shreg   <= {word[N_BITS-2:0], 1'b0};
          shcp    <= 1'b0;
          div_cnt <= '0;
          bit_cnt <= '0;
          state   <= SHIFT;
        end
        SHIFT: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            if (!shcp) begin
              shcp <= 1'b1;
            end else begin
              shcp <= 1'b0;
              if (bit_cnt == BIT_LAST) begin
                stcp  <= 1'b1;
                DS    <= 1'b0;
                state <= LATCH;
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
                DS      <= shreg[N_BITS-1];
                shreg   <= {shreg[N_BITS-2:0], 1'b0};
              end
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        LATCH: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            stcp    <= 1'b0;
            state   <= HOLD;
            if (en) OE <= 1'b0;
          end else begin
            div_cnt <= div_cnt + 1'b1;
          end
        end
        HOLD: begin
          if (slot_cnt == CNT_LAST) begin
            slot_cnt <= '0;
            k        <= k_next;
            if (en) begin
              state       <= LOAD;
              frame_start <= (k_next == '0);
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seg595_scan.sv
// Bench for seg595_scan: two instances (6-digit default-style and 4-digit
// active-low-select), a cycle monitor that rebuilds each shifted word and a
// reference model that predicts it from the digit index and input history.
module tb_seg595_scan;

  logic        clk = 1'b0;
  logic        rst_a, en_a, rst_b, en_b;
  logic [47:0] seg_a;
  logic [5:0]  blank_a;
  logic [31:0] seg_b;
  logic [3:0]  blank_b;
  logic        shcp_a, stcp_a, ds_a, oe_a, fs_a, busy_a;
  logic        shcp_b, stcp_b, ds_b, oe_b, fs_b, busy_b;
  logic [2:0]  state_a, state_b;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  bit b_done = 1'b0;

  // per-instance model state
  int          k_m[2]        = '{0, 0};
  int          bits_m[2]     = '{0, 0};
  int          first_rise[2] = '{0, 0};
  int          stcp_start[2] = '{0, 0};
  int          last_fs[2]    = '{0, 0};
  int          load_cyc[2]   = '{0, 0};
  int          idle_cyc[2]   = '{0, 0};
  int          latch_cnt[2]  = '{0, 0};
  int          last_k[2]     = '{0, 0};
  bit          fs_ok[2]      = '{0, 0};
  bit          p_shcp[2]     = '{0, 0};
  bit          p_stcp[2]     = '{0, 0};
  bit          p_busy[2]     = '{0, 0};
  logic [13:0] cap[2]        = '{14'h0, 14'h0};
  logic [13:0] last_word[2]  = '{14'h0, 14'h0};
  logic [47:0] h_seg[2][4];
  logic [5:0]  h_blank[2][4];
  logic        h_fs[2][4];
  logic [13:0] exp_q0[$];
  logic [13:0] exp_q1[$];

  seg595_scan #(
    .DIGITS(6), .SEG_W(8), .SHCP_DIV(2), .SCAN_CNT(64),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(0)
  ) dut_a (
    .clk(clk), .rst(rst_a), .en(en_a), .seg_data(seg_a), .blank(blank_a),
    .shcp(shcp_a), .stcp(stcp_a), .DS(ds_a), .OE(oe_a),
    .frame_start(fs_a), .busy(busy_a), .state_dbg(state_a)
  );

  seg595_scan #(
    .DIGITS(4), .SEG_W(8), .SHCP_DIV(1), .SCAN_CNT(32),
    .SEG_ACTIVE_LOW(1), .SEL_ACTIVE_LOW(1)
  ) dut_b (
    .clk(clk), .rst(rst_b), .en(en_b), .seg_data(seg_b), .blank(blank_b),
    .shcp(shcp_b), .stcp(stcp_b), .DS(ds_b), .OE(oe_b),
    .frame_start(fs_b), .busy(busy_b), .state_dbg(state_b)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", tag, obs, exp, cyc);
    end
  endtask

  // Expected 595 word: segments (blanked, active-low) above a one-hot select.
  function automatic logic [13:0] exp_word(input int id, input int k,
                                           input logic [47:0] sg, input logic [5:0] bl);
    int          nd;
    logic [7:0]  s;
    logic [5:0]  sel;
    logic [13:0] ws;
    nd  = (id == 1) ? 4 : 6;
    s   = bl[k] ? 8'h00 : sg[k*8 +: 8];
    s   = ~s;
    sel = 6'd1 << k;
    if (id == 1) sel = {2'b00, ~sel[3:0]};
    ws  = {6'b0, s};
    return (ws << nd) | {8'b0, sel};
  endfunction

  task automatic mon(input int id, input logic sh, input logic st, input logic ds,
                     input logic fs, input logic bz, input logic en, input logic rs,
                     input logic [47:0] sg, input logic [5:0] bl);
    int d, nb, nd, sc;
    logic [13:0] w;
    d  = (id == 1) ? 1 : 2;
    nb = (id == 1) ? 12 : 14;
    nd = (id == 1) ? 4 : 6;
    sc = (id == 1) ? 32 : 64;
    if (!rs) begin
      k_m[id] = 0; bits_m[id] = 0; cap[id] = '0;
      p_shcp[id] = 0; p_stcp[id] = 0; p_busy[id] = 0; fs_ok[id] = 0;
      if (id == 0) exp_q0.delete(); else exp_q1.delete();
      for (int i = 0; i < 4; i++) begin
        h_seg[id][i] = '0; h_blank[id][i] = '0; h_fs[id][i] = 1'b0;
      end
      return;
    end
    for (int i = 3; i > 0; i--) begin
      h_seg[id][i] = h_seg[id][i-1]; h_blank[id][i] = h_blank[id][i-1]; h_fs[id][i] = h_fs[id][i-1];
    end
    h_seg[id][0] = sg; h_blank[id][0] = bl; h_fs[id][0] = fs;
    if (!en) fs_ok[id] = 0;
    if (fs) begin
      if (fs_ok[id]) chk("fs_gap", cyc - last_fs[id], nd * sc);
      last_fs[id] = cyc;
      fs_ok[id]   = 1;
    end
    if (sh && !p_shcp[id]) begin
      if (bits_m[id] == 0) begin
        load_cyc[id]   = cyc - 1 - d;
        first_rise[id] = cyc;
        w = exp_word(id, k_m[id], h_seg[id][1+d], h_blank[id][1+d]);
        if (id == 0) exp_q0.push_back(w); else exp_q1.push_back(w);
        chk("fs_at_load", h_fs[id][1+d], k_m[id] == 0);
      end
      cap[id] = {cap[id][12:0], ds};
      bits_m[id]++;
    end
    if (st && !p_stcp[id]) begin
      chk("nbits", bits_m[id], nb);
      chk("stcp_pos", cyc - first_rise[id], 2*d*nb - d);
      if (id == 0) begin
        chk("q_size", exp_q0.size(), 1);
        if (exp_q0.size() > 0) chk("word_a", cap[id], exp_q0.pop_front());
      end else begin
        chk("q_size", exp_q1.size(), 1);
        if (exp_q1.size() > 0) chk("word_b", cap[id], exp_q1.pop_front());
      end
      last_word[id]  = cap[id];
      last_k[id]     = k_m[id];
      k_m[id]        = (k_m[id] + 1) % nd;
      bits_m[id]     = 0;
      cap[id]        = '0;
      stcp_start[id] = cyc;
      latch_cnt[id]++;
    end
    if (st) chk("no_overlap", sh, 1'b0);
    if (!st && p_stcp[id]) chk("stcp_width", cyc - stcp_start[id], d);
    if (!bz && p_busy[id]) idle_cyc[id] = cyc;
    p_shcp[id] = sh; p_stcp[id] = st; p_busy[id] = bz;
  endtask

  // monitor: outputs sampled on the falling edge
  always @(negedge clk) begin
    cyc++;
    mon(0, shcp_a, stcp_a, ds_a, fs_a, busy_a, en_a, rst_a, seg_a, blank_a);
    mon(1, shcp_b, stcp_b, ds_b, fs_b, busy_b, en_b, rst_b, {16'h0, seg_b}, {2'b00, blank_b});
  end

  task automatic wait_latch(input int id);
    int n0, t;
    n0 = latch_cnt[id];
    t  = 0;
    while (latch_cnt[id] == n0 && t < 400) begin
      @(posedge clk); #1; t++;
    end
    chk("latch_wait", latch_cnt[id] != n0, 1'b1);
  endtask

  // driver: instance A (directed scenarios plus random input churn)
  initial begin
    int t;
    rst_a = 1'b0; en_a = 1'b0; blank_a = '0;
    seg_a = {$urandom, $urandom};
    seg_a[7:0] = 8'h3F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_shcp", shcp_a, 1'b0);
    chk("rst_stcp", stcp_a, 1'b0);
    chk("rst_ds", ds_a, 1'b0);
    chk("rst_oe", oe_a, 1'b1);
    chk("rst_fs", fs_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    rst_a = 1'b1; en_a = 1'b1;
    wait_latch(0);
    chk("first_word", last_word[0], 14'h3001);
    chk("oe_in_latch", oe_a, 1'b1);
    @(posedge clk); #1;
    chk("stcp_done", stcp_a, 1'b0);
    chk("oe_low", oe_a, 1'b0);
    // random churn on data and blanking at arbitrary cycles
    for (int i = 0; i < 3*384; i++) begin
      @(posedge clk); #1;
      if ($urandom_range(0, 9) == 0) begin
        seg_a   = {$urandom, $urandom};
        blank_a = 6'($urandom);
      end
    end
    // blanked digit 2 with all segments requested
    wait_latch(0);
    for (int i = 0; i < 8 && last_k[0] != 1; i++) wait_latch(0);
    seg_a[23:16] = 8'hFF;
    blank_a = 6'b000100;
    wait_latch(0);
    chk("blank_k", last_k[0], 2);
    chk("blank_word", last_word[0], 14'h3FC4);
    // drop enable in the middle of digit 3's shift
    t = 0;
    while (!(k_m[0] == 3 && bits_m[0] >= 5) && t < 2000) begin
      @(posedge clk); #1; t++;
    end
    chk("find_d3", k_m[0], 3);
    en_a = 1'b0;
    t = latch_cnt[0];
    @(posedge clk); #1;
    chk("oe_off", oe_a, 1'b1);
    chk("busy_drain", busy_a, 1'b1);
    for (int i = 0; i < 200 && busy_a; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk); #1;
    chk("busy_off", busy_a, 1'b0);
    chk("drained_latch", latch_cnt[0] - t, 1);
    chk("idle_time", idle_cyc[0] - load_cyc[0], 64);
    repeat (20) @(posedge clk);
    #1;
    chk("idle_oe", oe_a, 1'b1);
    en_a = 1'b1;
    wait_latch(0);
    chk("resume_sel", last_word[0][5:0], 6'b010000);
    // reset in the middle of the latch pulse
    t = 0;
    while (!stcp_a && t < 400) begin
      @(posedge clk); #1; t++;
    end
    chk("find_latch", stcp_a, 1'b1);
    #3 rst_a = 1'b0;
    #1;
    chk("arst_stcp", stcp_a, 1'b0);
    chk("arst_shcp", shcp_a, 1'b0);
    chk("arst_ds", ds_a, 1'b0);
    chk("arst_oe", oe_a, 1'b1);
    chk("arst_busy", busy_a, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst_a = 1'b1;
    wait_latch(0);
    chk("post_rst_sel", last_word[0][5:0], 6'b000001);
    t = 0;
    while (!b_done && t < 5000) begin
      @(posedge clk); t++;
    end
    chk("b_done", b_done, 1'b1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // driver: instance B (4 digits, active-low select, fastest shift clock)
  initial begin
    int pk;
    rst_b = 1'b0; en_b = 1'b0; blank_b = '0;
    seg_b = $urandom;
    repeat (3) @(posedge clk);
    #1;
    chk("b_rst_oe", oe_b, 1'b1);
    chk("b_rst_busy", busy_b, 1'b0);
    rst_b = 1'b1; en_b = 1'b1;
    pk = -1;
    for (int i = 0; i < 12; i++) begin
      wait_latch(1);
      if (last_k[1] == 1) chk("b_sel1", last_word[1][3:0], 4'b1101);
      if (last_k[1] == 0 && pk == 3) chk("b_wrap", last_word[1][3:0], 4'b1110);
      pk = last_k[1];
      if ($urandom_range(0, 2) == 0) begin
        seg_b   = $urandom;
        blank_b = 4'($urandom);
      end
    end
    b_done = 1'b1;
  end

endmodule
